// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Step counter must be able to hold WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvsr_ext;
    logic           fits;

    // rem_in[WIDTH] acts as the carry out of the shift; if set, the shifted
    // value exceeds any divisor and the wrapped subtraction is still exact.
    always_comb begin
        shifted  = {rem_in[WIDTH-1:0], bit_in};
        dvsr_ext = {1'b0, divisor};
        fits     = rem_in[WIDTH] | (shifted >= dvsr_ext);
        rem_out  = shifted;
        q_bit    = 1'b0;
        if (fits) begin
            rem_out = shifted - dvsr_ext;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider, one quotient bit per clock, with a one-cycle
// done pulse when quotient/remainder are updated.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   BUSY  | one restoring step per clock, down-counter tracks steps left
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_sr;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] q_nxt;

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (q_sr[WIDTH-1]),
        .divisor (dvsr),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    assign q_nxt = {q_sr[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            q_sr      <= '0;
            dvsr      <= '0;
            rem       <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_sr  <= dividend;
                        dvsr  <= divisor;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    rem  <= rem_nxt;
                    q_sr <= q_nxt;
                    if (cnt == '0) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: latency-level behavioural model plus
// directed literal cases and randomized traffic.
module tb_divider;

    localparam int WIDTH = 4;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor  = '0;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    // Model: a request accepted while idle yields its arithmetic result,
    // published WIDTH clocks later with a single done cycle.
    int               m_left = 0;
    logic [WIDTH-1:0] m_q    = '0;
    logic [WIDTH-1:0] m_r    = '0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] p_q    = '0;
    logic [WIDTH-1:0] p_r    = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_q    = '0;
            m_r    = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_q    = p_q;
                    m_r    = p_r;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_left = WIDTH;
                if (divisor == '0) begin
                    p_q = '1;
                    p_r = dividend;
                end else begin
                    p_q = dividend / divisor;
                    p_r = dividend % divisor;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("done", 32'(done), 32'(m_done));
        check("quotient", 32'(quotient), 32'(m_q));
        check("remainder", 32'(remainder), 32'(m_r));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_div(input int a, input int b, input int eq, input int er, input string name);
        int  lat;
        step();
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        lat = 0;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            step();
            if (k == 1) begin
                start    = 1'b0;
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        check({name, "_q"}, 32'(quotient), 32'(eq));
        check({name, "_r"}, 32'(remainder), 32'(er));
        check({name, "_model_q"}, 32'(m_q), 32'(eq));
        check({name, "_model_r"}, 32'(m_r), 32'(er));
    endtask

    initial begin
        int pulses;
        int lat;

        #10;
        reset = 1'b0;
        step();
        check("reset_q", 32'(quotient), 32'd0);
        check("reset_r", 32'(remainder), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        run_div(6, 2, 3, 0, "d6_2");
        run_div(9, 4, 2, 1, "d9_4");
        run_div(15, 3, 5, 0, "d15_3");
        run_div(7, 3, 2, 1, "d7_3");
        run_div(8, 8, 1, 0, "d8_8");
        run_div(4, 5, 0, 4, "d4_5");
        run_div(0, 3, 0, 0, "d0_3");
        run_div(15, 1, 15, 0, "d15_1");
        run_div(9, 0, 15, 9, "d9_0");

        // Start pulsed mid-division must be ignored.
        step();
        start = 1'b1; dividend = 4'd9; divisor = 4'd4;
        lat = 0;
        pulses = 0;
        for (int k = 1; k <= WIDTH + 8; k++) begin
            step();
            start = (k == 2);
            if (k == 2) begin
                dividend = 4'd15;
                divisor  = 4'd3;
            end
            if (done) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        check("busy_start_latency", 32'(lat), 32'(WIDTH + 1));
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_q", 32'(quotient), 32'd2);
        check("busy_start_r", 32'(remainder), 32'd1);

        // Reset in the middle of a division abandons it.
        step();
        start = 1'b1; dividend = 4'd7; divisor = 4'd3;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_q", 32'(quotient), 32'd0);
        check("midreset_r", 32'(remainder), 32'd0);
        pulses = 0;
        for (int k = 0; k < WIDTH + 3; k++) begin
            step();
            if (done) pulses++;
        end
        check("midreset_pulses", 32'(pulses), 32'd0);
        run_div(6, 2, 3, 0, "after_reset");

        // Randomized traffic, including starts while busy, starts on done,
        // zero divisors and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            start    = ($urandom_range(0, 2) == 0);
            dividend = WIDTH'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            reset    = ($urandom_range(0, 299) == 0);
        end
        step();
        reset = 1'b0;
        start = 1'b0;
        repeat (WIDTH + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
